// File: rtl/conv_result_drain.sv
// Drains one captured tile of signed convolution sums as a stream of requantized
// 8-bit pixels: clamp negatives, round-half-up right shift, saturate at 255.
module conv_result_drain #(
   parameter int NUM_OUT = 40,
   parameter int DATA_W  = 32,
   parameter int SHIFT_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_OUT*DATA_W-1:0] conv_i,
   input  logic [SHIFT_W-1:0]        shift_amt,
   output logic [7:0]                pix_o,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic                      pix_last,
   output logic                      sat_flag,
   output logic                      done
);

   localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [SHIFT_W-1:0]       shift_q, shift_d;
   logic                     sat_q, sat_d;
   logic                     done_q, done_d;
   logic signed [DATA_W-1:0] buf_q [NUM_OUT];
   logic signed [DATA_W-1:0] buf_d [NUM_OUT];

   logic                     capture;
   logic signed [DATA_W-1:0] cur_lane;
   logic [DATA_W:0]          rnd, sum, shr;
   logic [7:0]               lane_pix;
   logic                     lane_sat;

   assign capture = (state_q == IDLE) && in_valid;

   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
         assign buf_d[gi] = capture ? conv_i[gi*DATA_W +: DATA_W] : buf_q[gi];
      end
   endgenerate

   // One extra bit of headroom so adding the rounding constant cannot wrap.
   always_comb begin
      cur_lane = buf_q[idx_q];
      rnd      = '0;
      if (shift_q != '0)
         rnd = {{DATA_W{1'b0}}, 1'b1} << (shift_q - 1'b1);
      sum      = {1'b0, cur_lane} + rnd;
      shr      = sum >> shift_q;
      lane_pix = '0;
      lane_sat = 1'b0;
      if (!cur_lane[DATA_W-1]) begin
         if (shr > (DATA_W+1)'(255)) begin
            lane_pix = 8'hFF;
            lane_sat = 1'b1;
         end else begin
            lane_pix = shr[7:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DRAIN;
               idx_d   = '0;
               shift_d = shift_amt;
               sat_d   = 1'b0;
            end
         end
         DRAIN: begin
            if (pix_ready) begin
               if (lane_sat)
                  sat_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
      end
   end

   // Tile contents are don't-care after reset, so the buffer carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OUT; i++)
         buf_q[i] <= buf_d[i];
   end

   assign in_ready  = (state_q == IDLE);
   assign pix_valid = (state_q == DRAIN);
   assign pix_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);
   assign pix_o     = (state_q == DRAIN) ? lane_pix : 8'h00;
   assign sat_flag  = sat_q;
   assign done      = done_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed-plus-random bench for conv_result_drain; expected pixels come from a
// plain-arithmetic requantization model applied to each loaded tile.
module tb_conv_result_drain;

   localparam int NUM_OUT = 40;
   localparam int DATA_W  = 32;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_OUT*DATA_W-1:0] conv_i;
   logic [4:0]                shift_amt;
   logic [7:0]                pix_o;
   logic                      pix_valid;
   logic                      pix_ready;
   logic                      pix_last;
   logic                      sat_flag;
   logic                      done;

   int checks   = 0;
   int failures = 0;
   int tile_no  = 0;

   logic signed [DATA_W-1:0] lanes      [NUM_OUT];
   logic signed [DATA_W-1:0] lanes_next [NUM_OUT];
   int                       shift_next;
   logic [7:0]               exp_pix [NUM_OUT];
   bit                       exp_sat [NUM_OUT];

   conv_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .conv_i    (conv_i),
      .shift_amt (shift_amt),
      .pix_o     (pix_o),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_last  (pix_last),
      .sat_flag  (sat_flag),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference requantizer: clamp, round half up, shift, saturate at 255.
   function automatic logic [7:0] q_model(input logic signed [DATA_W-1:0] v, input int s,
                                          output bit sat);
      longint r;
      sat = 1'b0;
      if (v < 0) return 8'd0;
      r = longint'(v);
      if (s > 0) r = r + (longint'(1) << (s - 1));
      r = r >> s;
      if (r > 255) begin
         sat = 1'b1;
         return 8'd255;
      end
      return 8'(r);
   endfunction

   task automatic set_expected(input int sh);
      for (int k = 0; k < NUM_OUT; k++) begin
         bit s;
         exp_pix[k] = q_model(lanes[k], sh, s);
         exp_sat[k] = s;
      end
   endtask

   task automatic drive_lanes_next();
      for (int k = 0; k < NUM_OUT; k++)
         conv_i[k*DATA_W +: DATA_W] = lanes_next[k];
      shift_amt = 5'(shift_next);
   endtask

   // Called #1 after an edge while idle; returns #1 after the capture edge.
   task automatic load(input int sh, input bit hold);
      for (int k = 0; k < NUM_OUT; k++)
         conv_i[k*DATA_W +: DATA_W] = lanes[k];
      shift_amt = 5'(sh);
      set_expected(sh);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_pix_valid", 64'(pix_valid), 64'd0);
      in_valid = 1'b1;
      tile_no++;
      $display("tile %0d load shift=%0d lane0=%0d lane39=%0d", tile_no, sh, lanes[0], lanes[NUM_OUT-1]);
      @(posedge clk); #1;
      in_valid = hold;
   endtask

   // bp: 0 always ready, 1 ready one cycle in three, 2 random.
   task automatic drain(input int bp, input bit noise, input bit chain, input int stop_at);
      int beat = 0;
      int cyc  = 0;
      int xfers = 0;
      bit sat_exp = 1'b0;
      while (beat < stop_at && cyc < 2000) begin
         bit pr;
         pr = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
         pix_ready = pr;
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_OUT; k++)
               conv_i[k*DATA_W +: DATA_W] = $urandom;
            shift_amt = 5'($urandom_range(0, 31));
         end
         check($sformatf("pix_valid b%0d", beat), 64'(pix_valid), 64'd1);
         check($sformatf("pix_o b%0d", beat), 64'(pix_o), 64'(exp_pix[beat]));
         check($sformatf("pix_last b%0d", beat), 64'(pix_last), 64'(beat == NUM_OUT-1));
         check($sformatf("sat_flag b%0d", beat), 64'(sat_flag), 64'(sat_exp));
         check("drain_in_ready", 64'(in_ready), 64'd0);
         check("drain_done", 64'(done), 64'd0);
         if (pr) begin
            if (exp_sat[beat]) sat_exp = 1'b1;
            if (beat == NUM_OUT-1) begin
               in_valid = chain;
               if (chain) drive_lanes_next();
            end
            beat++;
            xfers++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("drain_budget", 64'(beat), 64'(stop_at));
      if (stop_at == NUM_OUT) begin
         pix_ready = 1'b0;
         check("done_pulse", 64'(done), 64'd1);
         check("done_in_ready", 64'(in_ready), 64'd1);
         check("done_pix_valid", 64'(pix_valid), 64'd0);
         check("done_pix_last", 64'(pix_last), 64'd0);
         check("done_pix_o", 64'(pix_o), 64'd0);
         check("done_sat_flag", 64'(sat_flag), 64'(sat_exp));
         $display("tile %0d drained transfers=%0d cycles=%0d sat=%0d", tile_no, xfers, cyc, sat_exp);
         if (!chain) begin
            @(posedge clk); #1;
            check("post_done", 64'(done), 64'd0);
            check("post_pix_valid", 64'(pix_valid), 64'd0);
            check("post_sat_hold", 64'(sat_flag), 64'(sat_exp));
         end
      end
   endtask

   task automatic random_lanes();
      for (int k = 0; k < NUM_OUT; k++) begin
         case ($urandom_range(0, 3))
            0: lanes[k] = $urandom;
            1: lanes[k] = DATA_W'($urandom_range(0, 4095)) - 32'sd512;
            2: lanes[k] = 32'sh7FFFFFFF - DATA_W'($urandom_range(0, 3));
            default: lanes[k] = DATA_W'($urandom_range(0, 255));
         endcase
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      pix_ready = 1'b0;
      conv_i    = '0;
      shift_amt = '0;

      // Reset then idle
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_pix_valid", 64'(pix_valid), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_pix_o", 64'(pix_o), 64'd0);
      check("idle_pix_last", 64'(pix_last), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_sat", 64'(sat_flag), 64'd0);

      // Basic drain: lane k = 16k, shift 4
      for (int k = 0; k < NUM_OUT; k++) lanes[k] = DATA_W'(k * 16);
      load(4, 1'b0);
      drain(0, 1'b0, 1'b0, NUM_OUT);

      // Rounding, clamp and saturation at shift 2
      random_lanes();
      lanes[0] = 5; lanes[1] = 6; lanes[2] = -7; lanes[3] = 1023; lanes[4] = 32'sh7FFFFFFF;
      load(2, 1'b0);
      check("model_l0", 64'(exp_pix[0]), 64'd1);
      check("model_l1", 64'(exp_pix[1]), 64'd2);
      check("model_l2", 64'(exp_pix[2]), 64'd0);
      check("model_l3", 64'(exp_pix[3]), 64'd255);
      drain(0, 1'b0, 1'b0, NUM_OUT);

      // Shift 0 passes values straight through
      random_lanes();
      lanes[5] = 200;
      load(0, 1'b0);
      drain(2, 1'b0, 1'b0, NUM_OUT);

      // Backpressure 1-in-3 with in_valid noise during drain
      for (int t = 0; t < 3; t++) begin
         random_lanes();
         load($urandom_range(0, 31), 1'b0);
         drain((t == 0) ? 1 : 2, 1'b1, 1'b0, NUM_OUT);
      end

      // Back-to-back: A (100, s0) -> B (0x400, s2) -> A, in_valid held
      for (int k = 0; k < NUM_OUT; k++) begin
         lanes[k]      = 100;
         lanes_next[k] = 32'sh400;
      end
      shift_next = 2;
      load(0, 1'b1);
      drain(0, 1'b0, 1'b1, NUM_OUT);
      lanes = lanes_next;
      set_expected(2);
      tile_no++;
      @(posedge clk); #1;
      for (int k = 0; k < NUM_OUT; k++) lanes_next[k] = 100;
      shift_next = 0;
      drain(1, 1'b0, 1'b1, NUM_OUT);
      lanes = lanes_next;
      set_expected(0);
      tile_no++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain(0, 1'b0, 1'b0, NUM_OUT);

      // Reset mid-drain after 10 beats
      random_lanes();
      load($urandom_range(0, 8), 1'b0);
      drain(2, 1'b0, 1'b0, 10);
      rst       = 1'b1;
      pix_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_pix_valid", 64'(pix_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_pix_o", 64'(pix_o), 64'd0);
      check("mid_rst_sat", 64'(sat_flag), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      check("mid_rst_no_done", 64'(done), 64'd0);
      check("mid_rst_idle", 64'(pix_valid), 64'd0);
      random_lanes();
      load($urandom_range(0, 31), 1'b0);
      drain(0, 1'b0, 1'b0, NUM_OUT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
